// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic-light sequencer.
// Latency: n/a; backpressure: n/a.
package traffic_pkg;

  localparam int CNT_W_DEF    = 4;
  localparam int RED_T_DEF    = 5;
  localparam int GREEN_T_DEF  = 4;
  localparam int YELLOW_T_DEF = 2;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } phase_e;

  localparam logic [1:0] SEL_RED    = 2'd0;
  localparam logic [1:0] SEL_GREEN  = 2'd1;
  localparam logic [1:0] SEL_YELLOW = 2'd2;

endpackage

// File: rtl/phase_time_regs.sv
// Shadow/active phase-time registers; shadows are copied to active on commit.
// Latency: write visible as active on the commit edge; backpressure: none, writes always accepted.
module phase_time_regs
  import traffic_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int RED_T    = RED_T_DEF,
  parameter int GREEN_T  = GREEN_T_DEF,
  parameter int YELLOW_T = YELLOW_T_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             commit,
  output logic [CNT_W-1:0] red_time,
  output logic [CNT_W-1:0] green_time,
  output logic [CNT_W-1:0] yellow_time,
  output logic             cfg_pending
);

  logic [CNT_W-1:0] shadow     [3];
  logic [CNT_W-1:0] shadow_nxt [3];
  logic [CNT_W-1:0] active     [3];
  logic [2:0]       pending;
  logic [2:0]       wr;

  always_comb begin
    wr[0] = cfg_we && (cfg_sel == SEL_RED);
    wr[1] = cfg_we && (cfg_sel == SEL_GREEN);
    wr[2] = cfg_we && (cfg_sel == SEL_YELLOW);
    for (int i = 0; i < 3; i++) begin
      shadow_nxt[i] = wr[i] ? cfg_data : shadow[i];
    end
  end

  // A write landing on the commit edge is forwarded straight into active.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow[0] <= CNT_W'(RED_T);
      shadow[1] <= CNT_W'(GREEN_T);
      shadow[2] <= CNT_W'(YELLOW_T);
      active[0] <= CNT_W'(RED_T);
      active[1] <= CNT_W'(GREEN_T);
      active[2] <= CNT_W'(YELLOW_T);
      pending   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        shadow[i] <= shadow_nxt[i];
        if (commit) begin
          if (wr[i] || pending[i]) active[i] <= shadow_nxt[i];
          pending[i] <= 1'b0;
        end else begin
          pending[i] <= pending[i] | wr[i];
        end
      end
    end
  end

  assign red_time    = active[0];
  assign green_time  = active[1];
  assign yellow_time = active[2];
  assign cfg_pending = |pending;

endmodule

// File: rtl/traffic_light_fsm.sv
// Traffic-light sequencer: phase counter, FSM and lights driven by external comparator flags.
// Latency: flags act on the same-cycle count, outputs registered; backpressure: hold/tick=0 freezes state and count.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int RED_T    = RED_T_DEF,
  parameter int GREEN_T  = GREEN_T_DEF,
  parameter int YELLOW_T = YELLOW_T_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             hold,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             eq_red_time,
  input  logic             eq_green_time,
  input  logic             eq_yellow_time,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] red_time,
  output logic [CNT_W-1:0] green_time,
  output logic [CNT_W-1:0] yellow_time,
  output logic             light_red,
  output logic             light_green,
  output logic             light_yellow,
  output logic             phase_done,
  output logic             cfg_pending
);

  phase_e           state, state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             done_nxt;
  logic             commit;
  logic             eq_cur;

  phase_time_regs #(
    .CNT_W   (CNT_W),
    .RED_T   (RED_T),
    .GREEN_T (GREEN_T),
    .YELLOW_T(YELLOW_T)
  ) u_times (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .commit     (commit),
    .red_time   (red_time),
    .green_time (green_time),
    .yellow_time(yellow_time),
    .cfg_pending(cfg_pending)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    commit    = 1'b0;
    eq_cur    = 1'b0;
    case (state)
      RED:     eq_cur = eq_red_time;
      GREEN:   eq_cur = eq_green_time;
      YELLOW:  eq_cur = eq_yellow_time;
      default: eq_cur = 1'b0;
    endcase
    if (tick && !hold) begin
      if (eq_cur) begin
        count_nxt = '0;
        done_nxt  = 1'b1;
        case (state)
          RED:     state_nxt = GREEN;
          GREEN:   state_nxt = YELLOW;
          YELLOW: begin
            state_nxt = RED;
            commit    = 1'b1;
          end
          default: state_nxt = RED;
        endcase
      end else begin
        count_nxt = count + CNT_W'(1);
      end
    end
  end

  // Lights decode the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RED;
      count        <= '0;
      phase_done   <= 1'b0;
      light_red    <= 1'b1;
      light_green  <= 1'b0;
      light_yellow <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      phase_done   <= done_nxt;
      light_red    <= (state_nxt == RED);
      light_green  <= (state_nxt == GREEN);
      light_yellow <= (state_nxt == YELLOW);
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboarded bench: phase-level reference model predicts every cycle, monitor compares on negedge.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       rst, tick, hold, cfg_we;
  logic [1:0] cfg_sel;
  logic [3:0] cfg_data;
  logic       eq_red_time, eq_green_time, eq_yellow_time;
  logic [3:0] count, red_time, green_time, yellow_time;
  logic       light_red, light_green, light_yellow, phase_done, cfg_pending;
  logic [2:0] spur;

  always #5 clk = ~clk;

  traffic_light_fsm dut (
    .clk(clk), .rst(rst), .tick(tick), .hold(hold),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .eq_red_time(eq_red_time), .eq_green_time(eq_green_time), .eq_yellow_time(eq_yellow_time),
    .count(count), .red_time(red_time), .green_time(green_time), .yellow_time(yellow_time),
    .light_red(light_red), .light_green(light_green), .light_yellow(light_yellow),
    .phase_done(phase_done), .cfg_pending(cfg_pending)
  );

  // Comparator stand-in, plus injected flags for phases the model says are inactive.
  assign eq_red_time    = (count == red_time)    | spur[0];
  assign eq_green_time  = (count == green_time)  | spur[1];
  assign eq_yellow_time = (count == yellow_time) | spur[2];

  typedef struct packed {
    logic [3:0] cnt, rt, gt, yt;
    logic [2:0] lights; // {yellow, green, red}
    logic       done, pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase index 0=red,1=green,2=yellow; times per phase.
  int m_ph, m_cnt;
  int m_act[3], m_sh[3];
  bit m_pend[3];
  bit m_done;

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_done = 0;
    m_act = '{5, 4, 2}; m_sh = '{5, 4, 2}; m_pend = '{0, 0, 0};
  endtask

  task automatic model_edge(input bit r, t, h, we, input int sel, input int d);
    bit commit_now;
    commit_now = 0;
    if (r) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (t && !h) begin
      if (m_cnt == m_act[m_ph]) begin
        m_ph   = (m_ph + 1) % 3;
        m_cnt  = 0;
        m_done = 1;
        commit_now = (m_ph == 0);
      end else begin
        m_cnt = (m_cnt + 1) % 16;
      end
    end
    if (we && sel < 3) begin
      m_sh[sel]   = d;
      m_pend[sel] = 1;
    end
    if (commit_now) begin
      for (int i = 0; i < 3; i++) begin
        if (m_pend[i]) m_act[i] = m_sh[i];
        m_pend[i] = 0;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.cnt    = 4'(m_cnt);
    e.rt     = 4'(m_act[0]);
    e.gt     = 4'(m_act[1]);
    e.yt     = 4'(m_act[2]);
    e.lights = 3'(1 << m_ph);
    e.done   = m_done;
    e.pend   = m_pend[0] | m_pend[1] | m_pend[2];
    return e;
  endfunction

  task automatic step(input bit r, t, h, we, input logic [1:0] sel, input logic [3:0] d,
                      input logic [2:0] sp);
    rst = r; tick = t; hold = h; cfg_we = we; cfg_sel = sel; cfg_data = d;
    spur = sp & ~3'(1 << m_ph);
    model_edge(r, t, h, we, int'(sel), int'(d));
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int tick_every);
    for (int i = 0; i < n; i++) step(0, (i % tick_every) == 0, 0, 0, 2'd0, 4'd0, 3'b000);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      e = exp_q.pop_front();
      a = '{count, red_time, green_time, yellow_time,
            {light_yellow, light_green, light_red}, phase_done, cfg_pending};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got cnt=%h times=%h/%h/%h lights=%b done=%b pend=%b, want cnt=%h times=%h/%h/%h lights=%b done=%b pend=%b",
                 $time, a.cnt, a.rt, a.gt, a.yt, a.lights, a.done, a.pend,
                 e.cnt, e.rt, e.gt, e.yt, e.lights, e.done, e.pend);
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    spur = '0;
    // Reset and default sequence: 6/5/3 cycles per phase.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    run(30, 1);
    // Slow time base.
    run(90, 3);
    // Write green=1 during GREEN; commits at the next YELLOW->RED.
    guard = 0;
    while (m_ph != 1 && guard < 100) begin run(1, 1); guard++; end
    step(0, 1, 0, 1, 2'd1, 4'd1, 0);
    run(40, 1);
    // Write red=0 on the exact YELLOW->RED edge: forwarded, pending never shows.
    guard = 0;
    while (!(m_ph == 2 && m_cnt == m_act[2]) && guard < 100) begin run(1, 1); guard++; end
    step(0, 1, 0, 1, 2'd0, 4'd0, 0);
    run(20, 1);
    // Reserved sel and spurious yellow flag during RED.
    guard = 0;
    while (m_ph != 0 && guard < 100) begin run(1, 1); guard++; end
    step(0, 1, 0, 1, 2'd3, 4'd9, 3'b100);
    step(0, 0, 0, 0, 2'd0, 4'd0, 3'b110);
    run(10, 1);
    // Hold mid-GREEN, then reset mid-YELLOW with a pending write.
    guard = 0;
    while (m_ph != 1 && guard < 100) begin run(1, 1); guard++; end
    run(1, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0, 3'b111);
    step(0, 1, 0, 1, 2'd2, 4'd7, 0);
    guard = 0;
    while (m_ph != 2 && guard < 100) begin run(1, 1); guard++; end
    step(1, 1, 0, 0, 0, 0, 0);
    run(8, 1);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0, $urandom_range(3) != 0, $urandom_range(9) == 0,
           $urandom_range(6) == 0, 2'($urandom), 4'($urandom), 3'($urandom));
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
